// File: rtl/prach_reshape_xch_if.sv
// rtl/prach_reshape_xch_if.sv - sample stream, control and status bundle for prach_reshape_xch
interface prach_reshape_xch_if #(
  parameter int WIDTH     = 16,
  parameter int SIZE      = 8,
  parameter int CHN_WIDTH = 8
);
  localparam int IDX_W = $clog2(2 * SIZE);

  logic [WIDTH-1:0]     din_dq1;
  logic [WIDTH-1:0]     din_dq2;
  logic                 din_dv;
  logic [CHN_WIDTH-1:0] din_chn;
  logic                 sync_in;
  logic                 mode;
  logic                 err_clr;

  logic [WIDTH-1:0]     dout_dp1;
  logic [WIDTH-1:0]     dout_dp2;
  logic                 dout_dv;
  logic [CHN_WIDTH-1:0] dout_chn;
  logic [IDX_W-1:0]     dout_idx;
  logic                 sync_out;
  logic [1:0]           err;

  modport master (
    output din_dq1, din_dq2, din_dv, din_chn, sync_in, mode, err_clr,
    input  dout_dp1, dout_dp2, dout_dv, dout_chn, dout_idx, sync_out, err
  );

  modport slave (
    input  din_dq1, din_dq2, din_dv, din_chn, sync_in, mode, err_clr,
    output dout_dp1, dout_dp2, dout_dv, dout_chn, dout_idx, sync_out, err
  );
endinterface

// File: rtl/prach_reshape_xch.sv
// rtl/prach_reshape_xch.sv - PRACH two-lane block transpose/bypass with fixed SIZE+1 latency; optional error flags under PRACH_RESHAPE_XCH_ERR_EN
module prach_reshape_xch #(
  parameter int WIDTH     = 16,
  parameter int SIZE      = 8,
  parameter int CHN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  prach_reshape_xch_if.slave   bus
);
  localparam int IDX_W = $clog2(2 * SIZE);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(2 * SIZE - 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic [CHN_WIDTH-1:0] chn_q, chn_d;

  logic                 start;
  logic                 cur_act;
  logic [IDX_W-1:0]     cur_beat;
  logic                 cur_mode;
  logic [CHN_WIDTH-1:0] cur_chn;

  // Control info travels SIZE stages alongside the data, then into the output register.
  logic                 pv_q [SIZE];
  logic                 ps_q [SIZE];
  logic                 pa_q [SIZE];
  logic [IDX_W-1:0]     pb_q [SIZE];
  logic                 pm_q [SIZE];
  logic [CHN_WIDTH-1:0] pc_q [SIZE];

  // Sample history: lane 1 needs SIZE beats back, lane 2 needs 2*SIZE beats back.
  logic [WIDTH-1:0]     l1_sr_q [SIZE];
  logic [WIDTH-1:0]     l2_sr_q [2*SIZE];

  logic [WIDTH-1:0]     dp1_d, dp1_q, dp2_d, dp2_q;
  logic                 dv_d, dv_q, sync_d, sync_q;
  logic [IDX_W-1:0]     idx_d, idx_q;
  logic [CHN_WIDTH-1:0] ochn_d, ochn_q;

  logic                 o_mode;
  logic [IDX_W-1:0]     o_beat;

  // Block tracker: beat 0 comes from sync_in or the first valid while idle; mode/tag latch there.
  always_comb begin
    start    = bus.sync_in | (bus.din_dv & (state_q == S_IDLE));
    cur_act  = start | (state_q == S_ACTIVE);
    cur_beat = start ? '0 : cnt_q;
    cur_mode = start ? bus.mode : mode_q;
    cur_chn  = start ? bus.din_chn : chn_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = cur_mode;
    chn_d    = cur_chn;
    if (cur_act) begin
      if (cur_beat == LAST_BEAT) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = S_ACTIVE;
        cnt_d   = cur_beat + IDX_W'(1);
      end
    end
  end

  // Tracker state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      chn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      chn_q   <= chn_d;
    end
  end

  // Control delay line; cleared on reset so an aborted block leaves no valids behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SIZE; k++) begin
        pv_q[k] <= 1'b0;
        ps_q[k] <= 1'b0;
        pa_q[k] <= 1'b0;
        pb_q[k] <= '0;
        pm_q[k] <= 1'b0;
        pc_q[k] <= '0;
      end
    end else begin
      pv_q[0] <= bus.din_dv;
      ps_q[0] <= bus.sync_in;
      pa_q[0] <= cur_act;
      pb_q[0] <= cur_beat;
      pm_q[0] <= cur_mode;
      pc_q[0] <= cur_chn;
      for (int k = 1; k < SIZE; k++) begin
        pv_q[k] <= pv_q[k-1];
        ps_q[k] <= ps_q[k-1];
        pa_q[k] <= pa_q[k-1];
        pb_q[k] <= pb_q[k-1];
        pm_q[k] <= pm_q[k-1];
        pc_q[k] <= pc_q[k-1];
      end
    end
  end

  // Sample history shift registers; contents are don't-care until valid data has passed through.
  always_ff @(posedge clk) begin
    l1_sr_q[0] <= bus.din_dq1;
    l2_sr_q[0] <= bus.din_dq2;
    for (int k = 1; k < SIZE; k++) begin
      l1_sr_q[k] <= l1_sr_q[k-1];
    end
    for (int k = 1; k < 2 * SIZE; k++) begin
      l2_sr_q[k] <= l2_sr_q[k-1];
    end
  end

  // Output select: first half pairs A[j] with C[j] (C is arriving now), second half B with D.
  always_comb begin
    o_mode = pm_q[SIZE-1];
    o_beat = pb_q[SIZE-1];
    dp1_d  = l1_sr_q[SIZE-1];
    dp2_d  = l2_sr_q[SIZE-1];
    if (!o_mode) begin
      if (!o_beat[IDX_W-1]) begin
        dp1_d = l1_sr_q[SIZE-1];
        dp2_d = bus.din_dq1;
      end else begin
        dp1_d = l2_sr_q[2*SIZE-1];
        dp2_d = l2_sr_q[SIZE-1];
      end
    end
    dv_d   = pv_q[SIZE-1];
    sync_d = ps_q[SIZE-1];
    idx_d  = pv_q[SIZE-1] ? o_beat : '0;
    ochn_d = pa_q[SIZE-1] ? pc_q[SIZE-1] : ochn_q;
  end

  // Output register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp1_q  <= '0;
      dp2_q  <= '0;
      dv_q   <= 1'b0;
      sync_q <= 1'b0;
      idx_q  <= '0;
      ochn_q <= '0;
    end else begin
      dp1_q  <= dp1_d;
      dp2_q  <= dp2_d;
      dv_q   <= dv_d;
      sync_q <= sync_d;
      idx_q  <= idx_d;
      ochn_q <= ochn_d;
    end
  end

  assign bus.dout_dp1 = dp1_q;
  assign bus.dout_dp2 = dp2_q;
  assign bus.dout_dv  = dv_q;
  assign bus.sync_out = sync_q;
  assign bus.dout_idx = idx_q;
  assign bus.dout_chn = ochn_q;

`ifdef PRACH_RESHAPE_XCH_ERR_EN
  logic [1:0] err_d, err_q;

  // Sticky flags: bit0 missing valid mid-block, bit1 sync mid-block; a set beats a clear.
  always_comb begin
    err_d = bus.err_clr ? 2'b00 : err_q;
    if ((state_q == S_ACTIVE) && !bus.sync_in && !bus.din_dv) begin
      err_d[0] = 1'b1;
    end
    if ((state_q == S_ACTIVE) && bus.sync_in) begin
      err_d[1] = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 2'b00;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.err = 2'b00;
`endif

endmodule

// File: tb/tb_prach_reshape_xch.sv
// tb/tb_prach_reshape_xch.sv - scoreboard bench for prach_reshape_xch at SIZE=4, WIDTH=16
module tb_prach_reshape_xch;
  localparam int W = 16;
  localparam int S = 4;
  localparam int C = 8;
`ifdef PRACH_RESHAPE_XCH_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  idx;
    logic [7:0]  chn;
    logic [15:0] dp1;
    logic [15:0] dp2;
    logic        chk;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  exp_t exp_q [$];
  int   sync_q [$];

  logic         s_dv   [64];
  logic         s_sync [64];
  logic         s_mode [64];
  logic [15:0]  s_d1   [64];
  logic [15:0]  s_d2   [64];
  logic [7:0]   s_chn  [64];
  int           s_n;

  prach_reshape_xch_if #(.WIDTH(W), .SIZE(S), .CHN_WIDTH(C)) bus ();

  prach_reshape_xch #(.WIDTH(W), .SIZE(S), .CHN_WIDTH(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tb_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit blk_clean(input int b0);
    if (b0 + 2 * S > s_n) return 1'b0;
    for (int k = 0; k < 2 * S; k++) begin
      if (!s_dv[b0+k]) return 1'b0;
      if (k > 0 && s_sync[b0+k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // A[k]=lane1[b0+k], B[k]=lane2[b0+k], C[k]=lane1[b0+S+k], D[k]=lane2[b0+S+k]
  task automatic exp_data(input int b0, input int j, input bit m,
                          output logic [15:0] e1, output logic [15:0] e2);
    if (m) begin
      e1 = s_d1[b0+j];
      e2 = s_d2[b0+j];
    end else if (j < S) begin
      e1 = s_d1[b0+j];
      e2 = s_d1[b0+S+j];
    end else begin
      e1 = s_d2[b0+j-S];
      e2 = s_d2[b0+j];
    end
  endtask

  task automatic clear_stim();
    for (int k = 0; k < 64; k++) begin
      s_dv[k] = 1'b0; s_sync[k] = 1'b0; s_mode[k] = 1'b0;
      s_d1[k] = '0;   s_d2[k] = '0;     s_chn[k] = '0;
    end
    s_n = 0;
  endtask

  task automatic drive_idle();
    bus.din_dv = 1'b0; bus.sync_in = 1'b0; bus.err_clr = 1'b0;
    bus.din_dq1 = '0;  bus.din_dq2 = '0;   bus.din_chn = '0; bus.mode = 1'b0;
  endtask

  task automatic run_seq(input bit drain);
    bit          act = 1'b0;
    int          cnt = 0;
    int          b0 = 0;
    bit          bm = 1'b0;
    logic [7:0]  bc = '0;
    int          j;
    bit          start;
    exp_t        e;
    logic [15:0] e1, e2;
    for (int t = 0; t < s_n; t++) begin
      @(posedge clk); #1;
      bus.din_dv = s_dv[t]; bus.sync_in = s_sync[t]; bus.mode = s_mode[t];
      bus.din_dq1 = s_d1[t]; bus.din_dq2 = s_d2[t]; bus.din_chn = s_chn[t];
      bus.err_clr = 1'b0;
      start = s_sync[t] | (s_dv[t] & !act);
      if (start) begin
        b0 = t; bm = s_mode[t]; bc = s_chn[t]; j = 0;
      end else begin
        j = cnt;
      end
      if (s_dv[t]) begin
        e.cyc = 32'(cyc + S + 1);
        e.idx = 3'(j);
        e.chn = bc;
        e.chk = blk_clean(b0);
        e1 = '0; e2 = '0;
        if (e.chk) exp_data(b0, j, bm, e1, e2);
        e.dp1 = e1;
        e.dp2 = e2;
        exp_q.push_back(e);
      end
      if (s_sync[t]) sync_q.push_back(cyc + S + 1);
      if (start || act) begin
        if (j == 2 * S - 1) begin act = 1'b0; cnt = 0; end
        else begin act = 1'b1; cnt = j + 1; end
      end
    end
    if (drain) begin
      @(posedge clk); #1;
      drive_idle();
      repeat (2 * S + 4) @(posedge clk);
      #1;
      tb_check("sb_left", 32'(exp_q.size()), 32'd0);
      tb_check("sync_left", 32'(sync_q.size()), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    tb_check({tag, "_dv"},   32'(bus.dout_dv), 32'd0);
    tb_check({tag, "_sync"}, 32'(bus.sync_out), 32'd0);
    tb_check({tag, "_idx"},  32'(bus.dout_idx), 32'd0);
    tb_check({tag, "_chn"},  32'(bus.dout_chn), 32'd0);
    tb_check({tag, "_dp1"},  32'(bus.dout_dp1), 32'd0);
    tb_check({tag, "_dp2"},  32'(bus.dout_dp2), 32'd0);
    tb_check({tag, "_err"},  32'(bus.err), 32'd0);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    bus.err_clr = 1'b1;
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
    @(negedge clk);
    tb_check("err_after_clr", 32'(bus.err), 32'd0);
  endtask

  // Scoreboard: every output valid must match the next expected beat, on its expected cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.dout_dv) begin
        if (exp_q.size() == 0) begin
          tb_check("dv_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          tb_check("dv_cycle", 32'(cyc), e.cyc);
          tb_check("idx", 32'(bus.dout_idx), 32'(e.idx));
          tb_check("chn", 32'(bus.dout_chn), 32'(e.chn));
          if (e.chk) begin
            tb_check("dp1", 32'(bus.dout_dp1), 32'(e.dp1));
            tb_check("dp2", 32'(bus.dout_dp2), 32'(e.dp2));
          end
        end
      end else begin
        tb_check("idx_idle", 32'(bus.dout_idx), 32'd0);
      end
      if (bus.sync_out) begin
        if (sync_q.size() == 0) tb_check("sync_unexpected", 32'd1, 32'd0);
        else tb_check("sync_cycle", 32'(cyc), 32'(sync_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    drive_idle();
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs("rst_init");
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // transpose block
    clear_stim();
    s_n = 2 * S;
    for (int t = 0; t < 2 * S; t++) begin
      s_dv[t] = 1'b1; s_d1[t] = 16'(16'h10 + t); s_d2[t] = 16'(16'h20 + t); s_chn[t] = 8'h11;
    end
    run_seq(1'b1);

    // bypass block; mode and tag wiggle mid-block and must be ignored
    clear_stim();
    s_n = 2 * S;
    for (int t = 0; t < 2 * S; t++) begin
      s_dv[t] = 1'b1; s_d1[t] = 16'(16'h10 + t); s_d2[t] = 16'(16'h20 + t);
      s_mode[t] = (t == 0); s_chn[t] = (t == 0) ? 8'h42 : 8'h99;
    end
    run_seq(1'b1);

    // back-to-back blocks, tag 3 then 5
    clear_stim();
    s_n = 4 * S;
    for (int t = 0; t < 4 * S; t++) begin
      s_dv[t] = 1'b1; s_d1[t] = 16'($urandom); s_d2[t] = 16'($urandom);
      s_chn[t] = (t < 2 * S) ? 8'd3 : 8'd5;
    end
    s_chn[2] = 8'd7;
    run_seq(1'b1);

    // sync at beat 5 restarts the block
    clear_stim();
    s_n = 5 + 2 * S;
    for (int t = 0; t < s_n; t++) begin
      s_dv[t] = 1'b1; s_d1[t] = 16'(16'h100 + t); s_d2[t] = 16'(16'h200 + t); s_chn[t] = 8'(t);
    end
    s_sync[5] = 1'b1;
    run_seq(1'b1);
    @(negedge clk);
    tb_check("err_sync", 32'(bus.err), ERR_EN ? 32'd2 : 32'd0);
    pulse_clr();

    // valid gap at beat 3
    clear_stim();
    s_n = 2 * S;
    for (int t = 0; t < 2 * S; t++) begin
      s_dv[t] = (t != 3); s_d1[t] = 16'(16'h300 + t); s_d2[t] = 16'(16'h400 + t); s_chn[t] = 8'h21;
    end
    run_seq(1'b1);
    @(negedge clk);
    tb_check("err_gap", 32'(bus.err), ERR_EN ? 32'd1 : 32'd0);
    repeat (3) @(negedge clk);
    tb_check("err_gap_hold", 32'(bus.err), ERR_EN ? 32'd1 : 32'd0);
    pulse_clr();

    // reset during beat 4 for two cycles
    clear_stim();
    s_n = 4;
    for (int t = 0; t < 4; t++) begin
      s_dv[t] = 1'b1; s_d1[t] = 16'hABCD; s_d2[t] = 16'h1234; s_chn[t] = 8'h66;
    end
    run_seq(1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    sync_q.delete();
    @(negedge clk);
    check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("rst_mid2");
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    repeat (3 * S) @(posedge clk);

    // random blocks with random gaps and modes
    clear_stim();
    for (int b = 0; b < 3; b++) begin
      int g;
      bit m;
      logic [7:0] ch;
      g = int'($urandom_range(0, 2));
      m = 1'($urandom_range(0, 1));
      ch = 8'($urandom);
      s_n = s_n + g;
      for (int k = 0; k < 2 * S; k++) begin
        s_dv[s_n] = 1'b1; s_mode[s_n] = m; s_chn[s_n] = ch;
        s_d1[s_n] = 16'($urandom); s_d2[s_n] = 16'($urandom);
        s_n++;
      end
    end
    run_seq(1'b1);
    @(negedge clk);
    tb_check("err_final", 32'(bus.err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/prach_reshape_xch.md
PRACH_RESHAPE_XCH -- requirements
Module: prach_reshape_xch

Interface
REQ-001 SHALL have parameter WIDTH, default 16: sample width per lane.
REQ-002 SHALL have parameter SIZE, default 8: sub-block length in beats; power of two, at least 2.
REQ-003 SHALL have parameter CHN_WIDTH, default 8: channel tag width.
REQ-004 SHALL have ports: clk in 1, clock; rst in 1, reset, asynchronous, active-high.
REQ-005 SHALL have ports: din_dq1 in WIDTH, lane-1 sample; din_dq2 in WIDTH, lane-2 sample; din_dv in 1, input valid; din_chn in CHN_WIDTH, channel tag; sync_in in 1, frame sync.
REQ-006 SHALL have ports: mode in 1, 0 = transpose, 1 = bypass; err_clr in 1, clears the sticky error bits.
REQ-007 SHALL have ports: dout_dp1 out WIDTH; dout_dp2 out WIDTH; dout_dv out 1; dout_chn out CHN_WIDTH; dout_idx out $clog2(2*SIZE), output beat index; sync_out out 1; err out 2, sticky errors.

Function
REQ-008 SHALL treat input as blocks of 2*SIZE contiguous beats: first half is lane1 A[k], lane2 B[k]; second half is lane1 C[k], lane2 D[k]; k runs 0..SIZE-1.
REQ-009 SHALL start a block (beat 0) on din_dv=1 while idle, or on sync_in=1 at any time.
REQ-010 SHALL advance the beat counter every cycle while the block is active, and return to idle after beat 2*SIZE-1.
REQ-011 SHALL start a new block with no idle gap when din_dv=1 on the cycle after beat 2*SIZE-1.
REQ-012 In transpose mode, output beat j SHALL appear at cycle T0+SIZE+1+j, where T0 is the beat-0 cycle.
REQ-013 In transpose mode, for j<SIZE: dp1=A[j], dp2=C[j]; for j>=SIZE: dp1=B[j-SIZE], dp2=D[j-SIZE].
REQ-014 In bypass mode, dp1 and dp2 SHALL equal lane1 and lane2 delayed SIZE+1 cycles, with the same timing as transpose.
REQ-015 SHALL sample mode and din_chn at beat 0 only; changes mid-block have no effect until the next block.
REQ-016 dout_dv and sync_out SHALL equal din_dv and sync_in delayed SIZE+1 cycles.
REQ-017 dout_idx SHALL equal j when dout_dv=1 and 0 otherwise; dout_chn SHALL hold the tag captured for the block being output.
REQ-018 sync_in mid-block SHALL abort the current block and restart at beat 0; data already queued is still output unchanged.
REQ-019 Data outputs SHALL be don't-care (no X-propagation required) while dout_dv=0.

Reset
REQ-020 While rst=1, SHALL clear the counter to idle, the mode/tag latches, all valid/sync delay stages, and err.
REQ-021 While rst=1, SHALL drive dout_dv, sync_out, dout_idx, dout_chn, dout_dp1 and dout_dp2 to 0.
REQ-022 Internal sample storage SHALL NOT require reset.
REQ-023 Reset mid-block SHALL discard all in-flight beats; no dout_dv pulses may appear from the aborted block after reset releases.

Configuration
REQ-024 With macro PRACH_RESHAPE_XCH_ERR_EN defined, err[0] SHALL set sticky when din_dv=0 on an active beat 1..2*SIZE-1.
REQ-025 With PRACH_RESHAPE_XCH_ERR_EN defined, err[1] SHALL set sticky on sync_in during an active beat 1..2*SIZE-1.
REQ-026 With PRACH_RESHAPE_XCH_ERR_EN defined, both err bits SHALL clear on the cycle after err_clr=1; a simultaneous set wins over the clear.
REQ-027 Without PRACH_RESHAPE_XCH_ERR_EN, err SHALL be constant 0, err_clr SHALL be ignored, and no error logic SHALL be synthesised.

Verification (SIZE=4, WIDTH=16)
REQ-028 Transpose: lane1=0x10..0x17, lane2=0x20..0x27, dv high 8 cycles from T0 -> from T0+5, dp1=10,11,12,13,20,21,22,23 and dp2=14,15,16,17,24,25,26,27, with idx 0..7.
REQ-029 Bypass: same stimulus with mode=1 -> from T0+5, dp1=0x10..0x17 and dp2=0x20..0x27.
REQ-030 Back-to-back: two blocks with chn=3 then chn=5, dv continuous 16 cycles -> 16 contiguous outputs, idx wraps 7->0, dout_chn switches from 3 to 5 at the second idx 0.
REQ-031 Mid-block sync: sync_in at beat 5 -> counter restarts, sync_out appears 5 cycles later, err=2'b10 when ERR_EN is defined, err=0 without it.
REQ-032 dv gap at beat 3 -> err[0]=1 and holds until an err_clr pulse, then reads 0 on the next cycle.
REQ-033 Reset asserted at beat 4 for 2 cycles -> all outputs 0 during reset and no dout_dv after release until a new block is started.
